// File: rtl/lcd_panel_if_if.sv
// lcd_panel_if_if: bundle of the pixel-capture input and the panel write port of lcd_panel_if.
//   datain/din_valid  : raster pixel stream from lcd_ctrl (no backpressure)
//   px_*              : ready/valid pixel stream to the LCD panel with row/col tags and frame marks
//   overflow          : sticky window-dropped flag
//   frame_cnt         : frames fully delivered (wrapping)
//   frame_sum         : per-frame pixel sum, present only when FRAME_SUM_EN is defined
// Modports: master = lcd_panel_if itself, slave = the surrounding environment.
interface lcd_panel_if_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 8
);
  logic [DW-1:0]    datain;
  logic             din_valid;
  logic [DW-1:0]    px_data;
  logic [1:0]       px_row;
  logic [1:0]       px_col;
  logic             px_valid;
  logic             px_ready;
  logic             px_first;
  logic             px_last;
  logic             overflow;
  logic [CNT_W-1:0] frame_cnt;
`ifdef FRAME_SUM_EN
  logic [DW-1:0]    frame_sum;
`endif

  modport master (
`ifdef FRAME_SUM_EN
    output frame_sum,
`endif
    input  datain, din_valid, px_ready,
    output px_data, px_row, px_col, px_valid, px_first, px_last, overflow, frame_cnt
  );

  modport slave (
`ifdef FRAME_SUM_EN
    input  frame_sum,
`endif
    output datain, din_valid, px_ready,
    input  px_data, px_row, px_col, px_valid, px_first, px_last, overflow, frame_cnt
  );
endinterface

// File: rtl/lcd_panel_if.sv
// lcd_panel_if: captures 3x3 window bursts from lcd_ctrl into a ping-pong buffer and replays
// each captured window to the LCD panel as a ready/valid pixel stream.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : lcd_panel_if_if.master (datain/din_valid in, px_* out, px_ready in,
//           overflow, frame_cnt, optional frame_sum)
// Optional feature macro: FRAME_SUM_EN adds frame_sum, the modulo-2^DW sum of the frame being
// sent, valid alongside px_last.
module lcd_panel_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            reset,
  lcd_panel_if_if.master bus
);
  localparam int unsigned NPIX = W * W;
  localparam int unsigned CW   = $clog2(NPIX);

  typedef enum logic {StIdle, StSend} state_e;

  // Pixel storage has no reset; contents are only read once the matching full flag is set.
  logic [DW-1:0]    r_buf [2][NPIX];
  logic [1:0]       r_full;
  logic             r_wr_sel, r_rd_sel, r_drop, r_overflow;
  logic [CW-1:0]    r_wr_cnt, r_rd_cnt;
  state_e           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [DW-1:0]    r_px_data;
  logic [1:0]       r_px_row, r_px_col;
  logic             r_px_valid, r_px_first, r_px_last;

  logic             w_wr_last, w_drop_start, w_store, w_set_full;
  logic             w_accept, w_frame_done;
  logic [1:0]       w_full_nxt;
  state_e           w_state_nxt;
  logic [CW-1:0]    w_rd_cnt_nxt, w_load_idx;
  logic             w_rd_sel_nxt, w_load, w_load_sel, w_go_idle;

  // A burst is dropped as a whole when its first byte finds the write buffer still unread.
  assign w_wr_last    = bus.din_valid && (r_wr_cnt == CW'(NPIX - 1));
  assign w_drop_start = bus.din_valid && (r_wr_cnt == '0) && r_full[r_wr_sel];
  assign w_store      = bus.din_valid && !w_drop_start && !r_drop;
  assign w_set_full   = w_wr_last && !r_drop;

  assign w_accept     = r_px_valid && bus.px_ready;
  assign w_frame_done = w_accept && (r_rd_cnt == CW'(NPIX - 1));

  // Write-side set and read-side clear never hit the same buffer on one edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_frame_done) w_full_nxt[r_rd_sel] = 1'b0;
    if (w_set_full)   w_full_nxt[r_wr_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    w_rd_sel_nxt = r_rd_sel;
    w_load       = 1'b0;
    w_load_sel   = r_rd_sel;
    w_load_idx   = r_rd_cnt;
    w_go_idle    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_full[r_rd_sel]) begin
          w_state_nxt  = StSend;
          w_rd_cnt_nxt = '0;
          w_load       = 1'b1;
          w_load_idx   = '0;
        end
      end
      StSend: begin
        if (w_accept) begin
          if (!w_frame_done) begin
            w_rd_cnt_nxt = r_rd_cnt + 1'b1;
            w_load       = 1'b1;
            w_load_idx   = r_rd_cnt + 1'b1;
          end else begin
            w_rd_sel_nxt = ~r_rd_sel;
            // Other buffer already complete: chain straight into it without a bubble.
            if (r_full[~r_rd_sel]) begin
              w_rd_cnt_nxt = '0;
              w_load       = 1'b1;
              w_load_sel   = ~r_rd_sel;
              w_load_idx   = '0;
            end else begin
              w_state_nxt = StIdle;
              w_go_idle   = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_wr_sel][r_wr_cnt] <= bus.datain;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full      <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_drop      <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_state     <= StIdle;
      r_frame_cnt <= '0;
      r_px_data   <= '0;
      r_px_row    <= '0;
      r_px_col    <= '0;
      r_px_valid  <= 1'b0;
      r_px_first  <= 1'b0;
      r_px_last   <= 1'b0;
    end else begin
      if (bus.din_valid) r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
      if (w_drop_start)   r_drop <= 1'b1;
      else if (w_wr_last) r_drop <= 1'b0;
      if (w_set_full)   r_wr_sel    <= ~r_wr_sel;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_overflow <= r_overflow | w_drop_start;
      r_full     <= w_full_nxt;
      r_state    <= w_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      if (w_load) begin
        r_px_valid <= 1'b1;
        r_px_data  <= r_buf[w_load_sel][w_load_idx];
        r_px_row   <= 2'(w_load_idx / CW'(W));
        r_px_col   <= 2'(w_load_idx % CW'(W));
        r_px_first <= (w_load_idx == '0);
        r_px_last  <= (w_load_idx == CW'(NPIX - 1));
      end else if (w_go_idle) begin
        r_px_valid <= 1'b0;
        r_px_data  <= '0;
        r_px_row   <= '0;
        r_px_col   <= '0;
        r_px_first <= 1'b0;
        r_px_last  <= 1'b0;
      end
    end
  end

`ifdef FRAME_SUM_EN
  // Sum built while writing, so it is ready the moment the buffer is marked full.
  logic [DW-1:0] r_sum [2];
  logic [DW-1:0] r_frame_sum;

  always_ff @(posedge clk) begin
    if (w_store) r_sum[r_wr_sel] <= (r_wr_cnt == '0) ? bus.datain : r_sum[r_wr_sel] + bus.datain;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_sum <= '0;
    end else if (w_load) begin
      r_frame_sum <= (w_load_idx == CW'(NPIX - 1)) ? r_sum[w_load_sel] : '0;
    end else if (w_go_idle) begin
      r_frame_sum <= '0;
    end
  end

  assign bus.frame_sum = r_frame_sum;
`endif

  assign bus.px_data   = r_px_data;
  assign bus.px_row    = r_px_row;
  assign bus.px_col    = r_px_col;
  assign bus.px_valid  = r_px_valid;
  assign bus.px_first  = r_px_first;
  assign bus.px_last   = r_px_last;
  assign bus.overflow  = r_overflow;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_lcd_panel_if.sv
// Testbench for lcd_panel_if: stimulus pushes expected frames into a queue, a negedge monitor
// pops and compares every presented pixel against a frame-level model of capture and replay.
module tb_lcd_panel_if;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  lcd_panel_if_if #(.DW(8), .CNT_W(8)) bus ();

  lcd_panel_if #(.DW(8), .W(3), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         row;
    int         col;
    bit         first;
    bit         last;
    logic [7:0] sum;
    int         avail;
  } exp_t;

  // Frame-level model state
  exp_t       q[$];
  int         cyc       = 0;
  int         pending   = 0;   // complete frames captured but not yet fully delivered
  int         in_cnt    = 0;
  bit         cur_drop  = 0;
  logic [7:0] bytes[9];
  bit         exp_ovf   = 0;
  int         exp_frames = 0;
  int         last_end  = 0;   // edge at which the previous frame's last pixel was accepted
  int         sent      = 0;   // pixels of the current frame accepted so far
  int         rmode     = 0;   // 0: ready=1, 1: ready=0, 2: toggle, 3: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.px_ready = 1'b1;
      1: bus.px_ready = 1'b0;
      2: bus.px_ready = ~bus.px_ready;
      default: bus.px_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard: outputs reflect edges up to cyc; inputs seen here act on edge cyc+1.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      pending    = 0;
      in_cnt     = 0;
      cur_drop   = 0;
      exp_ovf    = 0;
      exp_frames = 0;
      last_end   = 0;
      sent       = 0;
    end else begin
      bit exp_valid;
      exp_valid = 0;
      if (q.size() > 0) begin
        int start;
        start = (q[0].avail > last_end) ? q[0].avail : last_end;
        exp_valid = (cyc >= start);
      end
      chk("px_valid", 32'(bus.px_valid), 32'(exp_valid));
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_frames));
      chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
      if (bus.px_valid && q.size() > 0) begin
        chk("px_data", 32'(bus.px_data), 32'(q[0].d));
        chk("px_row", 32'(bus.px_row), 32'(q[0].row));
        chk("px_col", 32'(bus.px_col), 32'(q[0].col));
        chk("px_first", 32'(bus.px_first), 32'(q[0].first));
        chk("px_last", 32'(bus.px_last), 32'(q[0].last));
`ifdef FRAME_SUM_EN
        chk("frame_sum", 32'(bus.frame_sum), q[0].last ? 32'(q[0].sum) : 32'd0);
`endif
      end
      if (bus.din_valid) begin
        if (in_cnt == 0) begin
          cur_drop = (pending >= 2);
          if (cur_drop) exp_ovf = 1;
        end
        bytes[in_cnt] = bus.datain;
        in_cnt++;
        if (in_cnt == 9) begin
          in_cnt = 0;
          if (!cur_drop) begin
            logic [7:0] s;
            s = 8'd0;
            for (int i = 0; i < 9; i++) s = s + bytes[i];
            for (int i = 0; i < 9; i++) begin
              exp_t e;
              e.d = bytes[i]; e.row = i / 3; e.col = i % 3;
              e.first = (i == 0); e.last = (i == 8); e.sum = s; e.avail = cyc + 2;
              q.push_back(e);
            end
            pending++;
          end
        end
      end
      if (bus.px_valid && bus.px_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        sent++;
        if (e.last) begin
          pending--;
          exp_frames = (exp_frames + 1) % 256;
          last_end = cyc + 1;
          sent = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [7:0] base, input logic [7:0] incr, input int gap_pct,
                       input bit rnd);
    for (int i = 0; i < 9; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.din_valid = 1'b0;
        step();
      end
      bus.din_valid = 1'b1;
      bus.datain    = rnd ? 8'($urandom) : base + 8'(i) * incr;
      step();
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || in_cnt != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: drain timeout, %0d pixels still expected", name, q.size());
    end
    repeat (3) step();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(bus.px_valid), 32'd0);
    chk({name, "_data"}, 32'(bus.px_data), 32'd0);
    chk({name, "_row"}, 32'(bus.px_row), 32'd0);
    chk({name, "_col"}, 32'(bus.px_col), 32'd0);
    chk({name, "_first"}, 32'(bus.px_first), 32'd0);
    chk({name, "_last"}, 32'(bus.px_last), 32'd0);
    chk({name, "_ovf"}, 32'(bus.overflow), 32'd0);
    chk({name, "_fcnt"}, 32'(bus.frame_cnt), 32'd0);
`ifdef FRAME_SUM_EN
    chk({name, "_sum"}, 32'(bus.frame_sum), 32'd0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int n;
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    bus.datain    = 8'd0;
    bus.px_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Single frame, first-pixel latency checked by the monitor's availability model
    burst(8'h01, 8'h01, 0, 0);
    drain("single", 200);
    chk("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Back-to-back bursts: no bubble between frames, no overflow
    burst(8'h10, 8'h01, 0, 0);
    burst(8'h20, 8'h01, 0, 0);
    drain("b2b", 200);
    chk("t2_frame_cnt", 32'(bus.frame_cnt), 32'd3);
    chk("t2_overflow", 32'(bus.overflow), 32'd0);

    // All-0xFF frame (wrapping sum)
    burst(8'hFF, 8'h00, 0, 0);
    drain("ff", 200);

    // Stalled panel: A, B captured, C dropped, then D accepted
    rmode = 1;
    step();
    burst(8'h40, 8'h01, 0, 0);
    burst(8'h50, 8'h01, 0, 0);
    burst(8'h60, 8'h01, 0, 0);
    repeat (5) step();
    rmode = 0;
    drain("stall", 300);
    chk("t3_frame_cnt", 32'(bus.frame_cnt), 32'd6);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
    burst(8'h70, 8'h01, 0, 0);
    drain("after_drop", 200);
    chk("t3d_frame_cnt", 32'(bus.frame_cnt), 32'd7);

    // Toggling ready: stall hold and single acceptance
    rmode = 2;
    burst(8'h80, 8'h03, 0, 0);
    drain("toggle", 300);
    rmode = 0;
    step();

    // Reset after four pixels of a frame have been accepted
    burst(8'h90, 8'h01, 0, 0);
    n = 0;
    while (sent < 4 && n < 100) begin
      step();
      n++;
    end
    chk("midreset_reached", 32'(sent >= 4), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    step();
    reset = 1'b1;
    step();
    burst(8'h30, 8'h01, 0, 0);
    drain("post_reset", 200);
    chk("t5_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Random bursts, random gaps, random backpressure
    rmode = 3;
    for (int b = 0; b < 40; b++) begin
      burst(8'h00, 8'h00, 25, 1);
      repeat ($urandom_range(0, 3)) step();
    end
    rmode = 0;
    drain("random", 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
